// File: rtl/automata_ctrl_pkg.sv
// Shared types and default sizing for the automaton run controller and its report FIFO.
package automata_ctrl_pkg;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_NUM_REPORT = 4;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_IDX_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DRAIN  = 2'd3
  } run_state_e;

  typedef struct packed {
    logic [$clog2(DEF_NUM_REQ)-1:0] req_id;
    logic [DEF_IDX_W-1:0]           index;
    logic [DEF_NUM_REPORT-1:0]      vector;
  } rpt_rec_t;

endpackage

// File: rtl/automata_rpt_fifo.sv
// Circular report FIFO; the head entry is presented combinationally from the storage registers.
module automata_rpt_fifo
  import automata_ctrl_pkg::*;
#(
  parameter type T     = rpt_rec_t,
  parameter int  DEPTH = DEF_FIFO_DEPTH,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  T              data_i,
  input  logic          pop_i,
  output T              head_o,
  output logic [CW-1:0] count_o
);

  T              mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  always_comb begin
    do_pop  = pop_i && (count != '0);
    do_push = push_i && ((count != CW'(DEPTH)) || do_pop);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= data_i;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_o  = mem[rd_ptr];
  assign count_o = count;

endmodule

// File: rtl/automata_run_ctrl.sv
// Arbitrates symbol-stream sessions onto one automaton and queues its reports with the
// owning requester and the index of the symbol that produced them.
module automata_run_ctrl
  import automata_ctrl_pkg::*;
#(
  parameter int  NUM_REQ    = DEF_NUM_REQ,
  parameter int  NUM_REPORT = DEF_NUM_REPORT,
  parameter int  FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int  IDX_W      = DEF_IDX_W,
  localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  input  logic [NUM_REQ*8-1:0]  req_symbol_i,
  input  logic [NUM_REQ-1:0]    req_last_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  output logic                  am_reset_o,
  output logic                  am_run_o,
  output logic [7:0]            am_symbol_o,
  input  logic [NUM_REPORT-1:0] am_report_i,
  output logic                  rpt_valid_o,
  input  logic                  rpt_ready_i,
  output logic [ID_W-1:0]       rpt_req_id_o,
  output logic [IDX_W-1:0]      rpt_index_o,
  output logic [NUM_REPORT-1:0] rpt_vector_o,
  output logic                  busy_o
);

  typedef struct packed {
    logic [ID_W-1:0]       req_id;
    logic [IDX_W-1:0]      index;
    logic [NUM_REPORT-1:0] vector;
  } rec_t;

  run_state_e       state;
  run_state_e       state_next;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  grant_id;
  logic [ID_W-1:0]  arb_id;
  logic             arb_hit;
  logic [IDX_W-1:0] sym_idx;
  logic [IDX_W-1:0] infl_idx;
  logic             infl;
  logic [7:0]       sym_hold;
  logic [7:0]       cur_sym;
  logic             am_reset_q;
  logic             room;
  logic             accept;
  logic             push;
  logic             pop;
  logic [CW-1:0]    fifo_count;
  rec_t             push_rec;
  rec_t             head_rec;

  // Round-robin search starting at rr_ptr.
  always_comb begin
    arb_hit = 1'b0;
    arb_id  = rr_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!arb_hit && req_valid_i[(int'(rr_ptr) + i) % NUM_REQ]) begin
        arb_hit = 1'b1;
        arb_id  = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
      end else begin
        arb_hit = arb_hit;
      end
    end
  end

  // Credit check counts the report that may still arrive for the previous accept.
  always_comb begin
    cur_sym = req_symbol_i[8*int'(grant_id) +: 8];
    room    = ({1'b0, fifo_count} + {{CW{1'b0}}, infl}) < (CW+1)'(FIFO_DEPTH);
    accept  = (state == ST_STREAM) && req_valid_i[grant_id] && room;
    push    = infl && (am_report_i != '0);
    pop     = rpt_ready_i && rpt_valid_o;
    push_rec = '{req_id: grant_id, index: infl_idx, vector: am_report_i};
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (arb_hit) state_next = ST_FLUSH;
        else         state_next = ST_IDLE;
      end
      ST_FLUSH: state_next = ST_STREAM;
      ST_STREAM: begin
        if (accept && req_last_i[grant_id]) state_next = ST_DRAIN;
        else                                state_next = ST_STREAM;
      end
      ST_DRAIN: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    req_ready_o = '0;
    if ((state == ST_STREAM) && room) begin
      req_ready_o[grant_id] = 1'b1;
    end else begin
      req_ready_o = '0;
    end
    am_run_o    = accept;
    am_symbol_o = accept ? cur_sym : sym_hold;
    busy_o      = (state != ST_IDLE);
    am_reset_o  = am_reset_q;
  end

  // Session datapath; am_reset_q powers up high so the automaton is held during reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      am_reset_q <= 1'b1;
      rr_ptr     <= '0;
      grant_id   <= '0;
      sym_idx    <= '0;
      infl_idx   <= '0;
      infl       <= 1'b0;
      sym_hold   <= 8'h00;
    end else begin
      am_reset_q <= (state_next == ST_FLUSH);
      infl       <= accept;
      if ((state == ST_IDLE) && arb_hit) begin
        grant_id <= arb_id;
      end
      if (state == ST_FLUSH) begin
        sym_idx <= '0;
      end else if (accept) begin
        sym_idx <= sym_idx + IDX_W'(1);
      end
      if (accept) begin
        infl_idx <= sym_idx;
        sym_hold <= cur_sym;
      end
      if (state == ST_DRAIN) begin
        rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
      end
    end
  end

  automata_rpt_fifo #(
    .T     (rec_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (push_rec),
    .pop_i   (pop),
    .head_o  (head_rec),
    .count_o (fifo_count)
  );

  assign rpt_valid_o  = (fifo_count != '0);
  assign rpt_req_id_o = head_rec.req_id;
  assign rpt_index_o  = head_rec.index;
  assign rpt_vector_o = head_rec.vector;

endmodule

// File: tb/tb_automata_run_ctrl.sv
// Bench for automata_run_ctrl: queue-based session model checked every cycle, plus directed
// scenarios with literal expectations.
module tb_automata_run_ctrl;

  localparam int NR = 4;
  localparam int NP = 4;
  localparam int FD = 4;
  localparam int IW = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   req_valid;
  logic [NR*8-1:0] req_symbol;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ready;
  logic            am_reset;
  logic            am_run;
  logic [7:0]      am_symbol;
  logic [NP-1:0]   am_report;
  logic            rpt_valid;
  logic            rpt_ready;
  logic [1:0]      rpt_req_id;
  logic [IW-1:0]   rpt_index;
  logic [NP-1:0]   rpt_vector;
  logic            busy;

  always #5 clk = ~clk;

  automata_run_ctrl #(.NUM_REQ(NR), .NUM_REPORT(NP), .FIFO_DEPTH(FD), .IDX_W(IW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_symbol_i(req_symbol),
    .req_last_i(req_last), .req_ready_o(req_ready), .am_reset_o(am_reset), .am_run_o(am_run),
    .am_symbol_o(am_symbol), .am_report_i(am_report), .rpt_valid_o(rpt_valid),
    .rpt_ready_i(rpt_ready), .rpt_req_id_o(rpt_req_id), .rpt_index_o(rpt_index),
    .rpt_vector_o(rpt_vector), .busy_o(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {int id; int index; int vec;} rec_t;

  // Model: session phase 0 idle, 1 flush, 2 stream, 3 drain; reports as a plain queue.
  int   m_phase = 0;
  int   m_owner = 0;
  int   m_rr = 0;
  int   m_idx = 0;
  int   m_infl_idx = 0;
  bit   m_infl = 0;
  bit   m_rst_seen = 1;
  logic [7:0] m_sym = 8'h00;
  rec_t m_q[$];

  int   acc_seen = 0;
  int   run_cnt = 0;
  int   flush_cnt = 0;
  rec_t popped[$];
  logic [NR-1:0] grant_log[$];

  always @(negedge clk) begin : cmp_blk
    bit            room;
    bit            acc;
    bit            found;
    logic [NR-1:0] exp_ready;
    logic [7:0]    exp_sym;
    if (!rst_n) begin
      m_phase = 0; m_rr = 0; m_idx = 0; m_infl = 0; m_sym = 8'h00; m_rst_seen = 1;
      m_q.delete();
      check("rst_ready", req_ready, 0);
      check("rst_run", am_run, 0);
      check("rst_symbol", am_symbol, 0);
      check("rst_rpt_valid", rpt_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_am_reset", am_reset, 1);
    end else begin
      room      = (m_q.size() + int'(m_infl)) < FD;
      acc       = (m_phase == 2) && req_valid[m_owner] && room;
      exp_ready = (m_phase == 2 && room) ? NR'(1 << m_owner) : '0;
      exp_sym   = acc ? req_symbol[m_owner*8 +: 8] : m_sym;
      check("ready", req_ready, exp_ready);
      check("run", am_run, acc);
      check("symbol", am_symbol, exp_sym);
      check("busy", busy, m_phase != 0);
      check("am_reset", am_reset, (m_phase == 1) || m_rst_seen);
      check("rpt_valid", rpt_valid, m_q.size() != 0);
      if (m_q.size() != 0) begin
        check("rpt_req_id", rpt_req_id, m_q[0].id);
        check("rpt_index", rpt_index, m_q[0].index);
        check("rpt_vector", rpt_vector, m_q[0].vec);
      end
      if (am_run) begin
        run_cnt++;
        grant_log.push_back(req_ready);
      end
      if (am_reset && busy) flush_cnt++;
      if (rpt_valid && rpt_ready) popped.push_back('{int'(rpt_req_id), int'(rpt_index), int'(rpt_vector)});
      // advance to the state after the coming clock edge
      if (m_q.size() != 0 && rpt_ready) void'(m_q.pop_front());
      if (m_infl && am_report != '0) m_q.push_back('{m_owner, m_infl_idx, int'(am_report)});
      m_rst_seen = 0;
      if (acc) begin
        m_sym = exp_sym;
        acc_seen++;
      end
      case (m_phase)
        0: begin
          found = 0;
          for (int i = 0; i < NR; i++) begin
            if (!found && req_valid[(m_rr + i) % NR]) begin
              found = 1;
              m_owner = (m_rr + i) % NR;
              m_phase = 1;
            end
          end
        end
        1: begin m_phase = 2; m_idx = 0; acc_seen = 0; end
        2: if (acc && req_last[m_owner]) m_phase = 3;
        default: begin m_phase = 0; m_rr = (m_owner + 1) % NR; end
      endcase
      m_infl = acc;
      if (acc) begin
        m_infl_idx = m_idx;
        m_idx = (m_idx + 1) % (1 << IW);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit done;
    req_valid = '0; req_symbol = '0; req_last = '0; am_report = '0; rpt_ready = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;

    // Requester 2 sends 0x41, 0x42(last); report 0100 follows 0x42.
    flush_cnt = 0; run_cnt = 0;
    req_valid = 4'b0100; req_symbol[23:16] = 8'h41;
    repeat (3) cyc();
    req_symbol[23:16] = 8'h42; req_last = 4'b0100;
    cyc();
    req_valid = '0; req_last = '0; am_report = 4'b0100;
    cyc();
    am_report = '0;
    repeat (2) cyc();
    check("t1_flush_pulses", flush_cnt, 1);
    check("t1_run_cycles", run_cnt, 2);
    check("t1_rec_valid", rpt_valid, 1);
    check("t1_rec_id", rpt_req_id, 2);
    check("t1_rec_index", rpt_index, 1);
    check("t1_rec_vector", rpt_vector, 4'b0100);
    rpt_ready = 1'b1;
    cyc();
    rpt_ready = 1'b0;

    // Report on every symbol with the consumer stalled: four records, then one symbol per pop.
    run_cnt = 0;
    req_valid = 4'b0001; am_report = 4'b0001;
    for (int c = 0; c < 12; c++) begin
      req_symbol[7:0] = 8'($urandom);
      cyc();
    end
    check("t2_runs_until_full", run_cnt, 4);
    check("t2_full_valid", rpt_valid, 1);
    check("t2_stalled_run", am_run, 0);
    rpt_ready = 1'b1;
    cyc();
    rpt_ready = 1'b0;
    repeat (4) cyc();
    check("t2_runs_after_pop", run_cnt, 5);
    check("t2_popped_index", popped[$].index, 0);
    check("t2_popped_vector", popped[$].vec, 1);

    // Reset mid-stream with reports queued.
    rst_n = 1'b0;
    #1;
    check("t3_am_reset", am_reset, 1);
    check("t3_busy", busy, 0);
    check("t3_rpt_valid", rpt_valid, 0);
    check("t3_ready", req_ready, 0);
    check("t3_run", am_run, 0);
    cyc();
    req_valid = '0; am_report = '0;
    cyc();
    rst_n = 1'b1;
    cyc();

    // Requesters 0 and 1 together with rr_ptr back at 0.
    flush_cnt = 0; grant_log.delete();
    req_valid = 4'b0011; req_last = 4'b0011; rpt_ready = 1'b1;
    repeat (8) cyc();
    req_valid = '0; req_last = '0;
    repeat (3) cyc();
    check("t4_sessions", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check("t4_first_owner", grant_log[0], 4'b0001);
      check("t4_second_owner", grant_log[1], 4'b0010);
    end
    check("t4_flush_pulses", flush_cnt, 2);

    // Index wrap: reports on the symbols at index 0xFFFF and 0x0000.
    popped.delete();
    acc_seen = 0; done = 0;
    req_valid = 4'b0010;
    for (int c = 0; c < 70000 && !done; c++) begin
      am_report = (acc_seen == 65536 || acc_seen == 65537) ? 4'b1000 : 4'b0000;
      req_last = (acc_seen == 65537) ? 4'b0010 : 4'b0000;
      req_symbol[15:8] = 8'($urandom);
      cyc();
      done = (acc_seen >= 65538);
    end
    check("t5_completed", done, 1);
    req_valid = '0; req_last = '0; am_report = '0;
    repeat (4) cyc();
    check("t5_records", popped.size(), 2);
    if (popped.size() == 2) begin
      check("t5_first_index", popped[0].index, 16'hFFFF);
      check("t5_second_index", popped[1].index, 16'h0000);
      check("t5_owner", popped[1].id, 1);
      check("t5_vector", popped[0].vec, 4'b1000);
    end

    // Randomised traffic with occasional resets.
    for (int c = 0; c < 2500; c++) begin
      req_valid  = NR'($urandom | $urandom);
      req_symbol = {$urandom};
      req_last   = NR'($urandom & $urandom & $urandom);
      am_report  = ($urandom_range(0, 1) == 0) ? 4'b0000 : NP'($urandom);
      rpt_ready  = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
      end
      cyc();
    end
    req_valid = '0; rpt_ready = 1'b1;
    repeat (20) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/automata_run_ctrl.md
AUTOMATA_RUN_CTRL -- requirements
Module: automata_run_ctrl

Interface
REQ-001 Parameter NUM_REQ, default 4, number of symbol-stream requesters.
REQ-002 Parameter NUM_REPORT, default 4, width of the automaton report vector.
REQ-003 Parameter FIFO_DEPTH, default 4, report FIFO entries (power of 2, >=2).
REQ-004 Parameter IDX_W, default 16, symbol index counter width.
REQ-005 clk_i  in  1  sole clock, rising edge.
REQ-006 rst_ni  in  1  reset, asynchronous, active-low.
REQ-007 req_valid_i  in  NUM_REQ  per-requester symbol valid.
REQ-008 req_symbol_i  in  NUM_REQ*8  per-requester symbol, requester k at bits [8k+7:8k].
REQ-009 req_last_i  in  NUM_REQ  marks the final symbol of a session.
REQ-010 req_ready_o  out  NUM_REQ  symbol accepted when valid&ready.
REQ-011 am_reset_o  out  1  active-high synchronous reset to the automaton STEs.
REQ-012 am_run_o  out  1  automaton run enable, high only in accept cycles.
REQ-013 am_symbol_o  out  8  symbol driven to the automaton.
REQ-014 am_report_i  in  NUM_REPORT  automaton report outputs, OR of report STE active states.
REQ-015 rpt_valid_o / rpt_ready_i  out/in  1/1  report record handshake.
REQ-016 rpt_req_id_o  out  $clog2(NUM_REQ)  requester that owned the session.
REQ-017 rpt_index_o  out  IDX_W  index of the symbol that caused the report.
REQ-018 rpt_vector_o  out  NUM_REPORT  captured am_report_i value.
REQ-019 busy_o  out  1  high in every state except IDLE.

Function
REQ-020 FSM states: IDLE, FLUSH, STREAM, DRAIN.
REQ-021 IDLE: when any req_valid_i is high, the block grants round-robin starting at rr_ptr, latches grant_id, and moves to FLUSH.
REQ-022 FLUSH lasts exactly 1 cycle with am_reset_o=1, clears the index counter to 0, then moves to STREAM.
REQ-023 STREAM: only req_ready_o[grant_id] may be high; the grant holds until the accepted symbol carries req_last_i=1.
REQ-024 Accept condition: req_valid_i[grant_id] & (fifo_count + inflight) < FIFO_DEPTH, where inflight = accept in the previous cycle.
REQ-025 Accept cycle: am_run_o=1, am_symbol_o = the granted symbol, and the index is captured into the inflight register; the index counter increments after the accept.
REQ-026 Non-accept cycle: am_run_o=0 and am_symbol_o holds its last value.
REQ-027 am_report_i is sampled only in the cycle after an accept; if it is nonzero, {grant_id, inflight index, am_report_i} is pushed to the FIFO.
REQ-028 A report of zero pushes nothing, and the index still advances.
REQ-029 The index counter wraps from 2^IDX_W-1 to 0 with no flag.
REQ-030 After accepting the last symbol the FSM enters DRAIN for 1 cycle to sample the final report, then returns to IDLE with rr_ptr = grant_id+1 mod NUM_REQ.
REQ-031 FIFO: push and pop in the same cycle are legal at any count, including full; overflow is impossible by REQ-024.
REQ-032 rpt_* outputs come from the FIFO head registers; rpt_valid_o = (count != 0).
REQ-033 Deasserting req_valid_i mid-session stalls without releasing the grant.

Reset
REQ-034 While rst_ni=0: state=IDLE, rr_ptr=0, index=0, inflight=0, FIFO empty, req_ready_o=0, am_run_o=0, am_symbol_o=0, rpt_valid_o=0, busy_o=0.
REQ-035 While rst_ni=0, am_reset_o=1, so the automaton is held in reset.
REQ-036 Reset asserted mid-session discards the session and all queued reports.

Structure
REQ-037 Package automata_ctrl_pkg holds the FSM state enum, the report record struct {req_id, index, vector}, and the default parameter constants.
REQ-038 The report FIFO is the single sub-module, automata_rpt_fifo, parameterized on the record type and depth.

Verification
REQ-039 Requester 2 sends 0x41, 0x42(last) with a report of 4'b0100 after 0x42 -> one FLUSH pulse, am_run_o high 2 cycles, one record {2, 1, 4'b0100}.
REQ-040 Requesters 0 and 1 both valid in IDLE with rr_ptr=0 -> requester 0 session completes, then requester 1 runs with a fresh FLUSH; no interleaving.
REQ-041 rpt_ready_i=0 and a report on every symbol, depth 4 -> exactly 4 records queued, am_run_o stalls at 0, and the stream resumes one symbol per pop.
REQ-042 Full FIFO with push and pop in the same cycle -> count stays 4 and head order is preserved.
REQ-043 Index at 0xFFFF with report on the next two symbols -> records carry 0xFFFF then 0x0000.
REQ-044 rst_ni pulsed low mid-STREAM -> all outputs at reset values immediately, am_reset_o=1, FIFO empty, IDLE on release.
